// File: rtl/jtag_pkg.sv
// Shared TAP definitions: state encoding, instruction codes and the
// helper that maps a latched instruction onto the data register it selects.
package jtag_pkg;

   localparam int          IR_WIDTH       = 4;
   localparam logic [31:0] IDCODE_DEFAULT = 32'h149511C3;

   localparam logic [IR_WIDTH-1:0] IR_EXTEST         = 4'b0000;
   localparam logic [IR_WIDTH-1:0] IR_SAMPLE_PRELOAD = 4'b0001;
   localparam logic [IR_WIDTH-1:0] IR_IDCODE         = 4'b0010;
   localparam logic [IR_WIDTH-1:0] IR_DEBUG          = 4'b1000;
   localparam logic [IR_WIDTH-1:0] IR_MBIST          = 4'b1001;
   localparam logic [IR_WIDTH-1:0] IR_BYPASS         = 4'b1111;
   localparam logic [IR_WIDTH-1:0] IR_CAPTURE        = 4'b0101;

   typedef enum logic [3:0] {
      TEST_LOGIC_RESET = 4'd0,
      RUN_TEST_IDLE    = 4'd1,
      SELECT_DR_SCAN   = 4'd2,
      CAPTURE_DR       = 4'd3,
      SHIFT_DR         = 4'd4,
      EXIT1_DR         = 4'd5,
      PAUSE_DR         = 4'd6,
      EXIT2_DR         = 4'd7,
      UPDATE_DR        = 4'd8,
      SELECT_IR_SCAN   = 4'd9,
      CAPTURE_IR       = 4'd10,
      SHIFT_IR         = 4'd11,
      EXIT1_IR         = 4'd12,
      PAUSE_IR         = 4'd13,
      EXIT2_IR         = 4'd14,
      UPDATE_IR        = 4'd15
   } tap_state_e;

   typedef enum logic [2:0] {
      SRC_BYPASS = 3'd0,
      SRC_IDCODE = 3'd1,
      SRC_BSCAN  = 3'd2,
      SRC_MBIST  = 3'd3,
      SRC_DEBUG  = 3'd4
   } dr_src_e;

   // Unrecognised instructions fall back to the bypass register.
   function automatic dr_src_e dr_source(input logic [IR_WIDTH-1:0] ir);
      dr_src_e src;
      case (ir)
         IR_EXTEST, IR_SAMPLE_PRELOAD: src = SRC_BSCAN;
         IR_IDCODE:                    src = SRC_IDCODE;
         IR_MBIST:                     src = SRC_MBIST;
         IR_DEBUG:                     src = SRC_DEBUG;
         default:                      src = SRC_BYPASS;
      endcase
      return src;
   endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state IEEE 1149.1 TAP state machine with Moore strobe decode.
module jtag_tap_fsm
   import jtag_pkg::*;
(
   input  logic       tck,
   input  logic       trst,
   input  logic       tms,
   output tap_state_e state,
   output tap_state_e next_state,
   output logic       shift_dr,
   output logic       pause_dr,
   output logic       update_dr,
   output logic       capture_dr,
   output logic       shift_ir,
   output logic       capture_ir,
   output logic       update_ir
);

   // State register; trst wins over tms.
   always_ff @(posedge tck) begin
      if (trst) begin
         state <= TEST_LOGIC_RESET;
      end else begin
         state <= next_state;
      end
   end

   // Next-state transitions on tms.
   always_comb begin
      next_state = TEST_LOGIC_RESET;
      case (state)
         TEST_LOGIC_RESET: next_state = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
         RUN_TEST_IDLE:    next_state = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
         SELECT_DR_SCAN:   next_state = tms ? SELECT_IR_SCAN   : CAPTURE_DR;
         CAPTURE_DR:       next_state = tms ? EXIT1_DR         : SHIFT_DR;
         SHIFT_DR:         next_state = tms ? EXIT1_DR         : SHIFT_DR;
         EXIT1_DR:         next_state = tms ? UPDATE_DR        : PAUSE_DR;
         PAUSE_DR:         next_state = tms ? EXIT2_DR         : PAUSE_DR;
         EXIT2_DR:         next_state = tms ? UPDATE_DR        : SHIFT_DR;
         UPDATE_DR:        next_state = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
         SELECT_IR_SCAN:   next_state = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
         CAPTURE_IR:       next_state = tms ? EXIT1_IR         : SHIFT_IR;
         SHIFT_IR:         next_state = tms ? EXIT1_IR         : SHIFT_IR;
         EXIT1_IR:         next_state = tms ? UPDATE_IR        : PAUSE_IR;
         PAUSE_IR:         next_state = tms ? EXIT2_IR         : PAUSE_IR;
         EXIT2_IR:         next_state = tms ? UPDATE_IR        : SHIFT_IR;
         UPDATE_IR:        next_state = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
         default:          next_state = TEST_LOGIC_RESET;
      endcase
   end

   // Moore strobe decode of the state register.
   always_comb begin
      shift_dr   = (state == SHIFT_DR);
      pause_dr   = (state == PAUSE_DR);
      update_dr  = (state == UPDATE_DR);
      capture_dr = (state == CAPTURE_DR);
      shift_ir   = (state == SHIFT_IR);
      capture_ir = (state == CAPTURE_IR);
      update_ir  = (state == UPDATE_IR);
   end

endmodule

// File: rtl/jtag_tap_ctrl.sv
// TAP controller top: instruction register, IDCODE/BYPASS data registers,
// chain select decode and the registered TDO pad driver.
module jtag_tap_ctrl #(
   parameter int          IR_WIDTH     = 4,
   parameter logic [31:0] IDCODE_VALUE = 32'h149511C3
) (
   input  logic tck,
   input  logic trst,
   input  logic tms,
   input  logic tdi,
   output logic tdo_pad_o,
   output logic tdo_padoe_o,
   output logic shift_dr_o,
   output logic pause_dr_o,
   output logic update_dr_o,
   output logic capture_dr_o,
   output logic extest_select_o,
   output logic sample_preload_select_o,
   output logic mbist_select_o,
   output logic debug_select_o,
   output logic tdo_o,
   input  logic debug_tdi_i,
   input  logic bs_chain_tdi_i,
   input  logic mbist_tdi_i
);
   import jtag_pkg::*;

   tap_state_e          state_s;
   tap_state_e          next_state_s;
   logic                shift_ir_s;
   logic                capture_ir_s;
   logic                update_ir_s;
   logic [IR_WIDTH-1:0] ir_shift_r;
   logic [IR_WIDTH-1:0] ir_latched_r;
   logic [31:0]         idcode_r;
   logic                bypass_r;
   logic                tdo_mux_s;
   dr_src_e             dr_src_s;

   jtag_tap_fsm u_fsm (
      .tck        (tck),
      .trst       (trst),
      .tms        (tms),
      .state      (state_s),
      .next_state (next_state_s),
      .shift_dr   (shift_dr_o),
      .pause_dr   (pause_dr_o),
      .update_dr  (update_dr_o),
      .capture_dr (capture_dr_o),
      .shift_ir   (shift_ir_s),
      .capture_ir (capture_ir_s),
      .update_ir  (update_ir_s)
   );

   assign dr_src_s                = dr_source(ir_latched_r);
   assign extest_select_o         = (ir_latched_r == IR_EXTEST);
   assign sample_preload_select_o = (ir_latched_r == IR_SAMPLE_PRELOAD);
   assign mbist_select_o          = (ir_latched_r == IR_MBIST);
   assign debug_select_o          = (ir_latched_r == IR_DEBUG);
   assign tdo_o                   = tdi;

   // IR shift/latch; IDCODE is forced on the same edge that enters reset.
   always_ff @(posedge tck) begin
      if (trst) begin
         ir_shift_r   <= '0;
         ir_latched_r <= IR_IDCODE;
      end else begin
         if (capture_ir_s) begin
            ir_shift_r <= IR_CAPTURE;
         end else if (shift_ir_s) begin
            ir_shift_r <= {tdi, ir_shift_r[IR_WIDTH-1:1]};
         end else begin
            ir_shift_r <= ir_shift_r;
         end
         if (next_state_s == TEST_LOGIC_RESET) begin
            ir_latched_r <= IR_IDCODE;
         end else if (update_ir_s) begin
            ir_latched_r <= ir_shift_r;
         end else begin
            ir_latched_r <= ir_latched_r;
         end
      end
   end

   // IDCODE and bypass data registers.
   always_ff @(posedge tck) begin
      if (trst) begin
         idcode_r <= 32'h0000_0000;
         bypass_r <= 1'b0;
      end else begin
         if (capture_dr_o && (dr_src_s == SRC_IDCODE)) begin
            idcode_r <= IDCODE_VALUE;
         end else if (shift_dr_o && (dr_src_s == SRC_IDCODE)) begin
            idcode_r <= {tdi, idcode_r[31:1]};
         end else begin
            idcode_r <= idcode_r;
         end
         if (capture_dr_o && (dr_src_s == SRC_BYPASS)) begin
            bypass_r <= 1'b0;
         end else if (shift_dr_o && (dr_src_s == SRC_BYPASS)) begin
            bypass_r <= tdi;
         end else begin
            bypass_r <= bypass_r;
         end
      end
   end

   // Serial-out selection; outside shift states the pad keeps its last bit.
   always_comb begin
      tdo_mux_s = tdo_pad_o;
      if (shift_ir_s) begin
         tdo_mux_s = ir_shift_r[0];
      end else if (shift_dr_o) begin
         case (dr_src_s)
            SRC_IDCODE: tdo_mux_s = idcode_r[0];
            SRC_BSCAN:  tdo_mux_s = bs_chain_tdi_i;
            SRC_MBIST:  tdo_mux_s = mbist_tdi_i;
            SRC_DEBUG:  tdo_mux_s = debug_tdi_i;
            default:    tdo_mux_s = bypass_r;
         endcase
      end else begin
         tdo_mux_s = tdo_pad_o;
      end
   end

   // Registered pad driver.
   always_ff @(posedge tck) begin
      if (trst) begin
         tdo_pad_o   <= 1'b0;
         tdo_padoe_o <= 1'b0;
      end else begin
         tdo_pad_o   <= tdo_mux_s;
         tdo_padoe_o <= shift_ir_s | shift_dr_o;
      end
   end

endmodule

// File: doc/jtag_tap_ctrl.md
Name:
jtag_tap_ctrl

Overview:
IEEE 1149.1 TAP controller that drives the JTAG interface bundle. It decodes TMS into the 16-state TAP machine and holds the instruction register. It owns the IDCODE and BYPASS data registers. It decodes select lines for the boundary-scan, MBIST and debug chains and muxes the returned chain data onto the TDO pad.

Parameters:
IR_WIDTH, 4, instruction register width
IDCODE_VALUE, 32'h149511C3, device ID; bit 0 must be 1

Ports:
tck  input  1  JTAG clock; all flops on rising edge
trst  input  1  synchronous active-high reset
tms  input  1  test mode select
tdi  input  1  test data in
tdo_pad_o  output  1  registered TDO to pad
tdo_padoe_o  output  1  TDO pad output enable
shift_dr_o  output  1  state == SHIFT_DR
pause_dr_o  output  1  state == PAUSE_DR
update_dr_o  output  1  state == UPDATE_DR
capture_dr_o  output  1  state == CAPTURE_DR
extest_select_o  output  1  latched IR == EXTEST
sample_preload_select_o  output  1  latched IR == SAMPLE_PRELOAD
mbist_select_o  output  1  latched IR == MBIST
debug_select_o  output  1  latched IR == DEBUG
tdo_o  output  1  serial data to sub-module chains; equals tdi (combinational)
debug_tdi_i  input  1  return data from the debug chain
bs_chain_tdi_i  input  1  return data from the boundary-scan chain
mbist_tdi_i  input  1  return data from the MBIST chain

Behaviour:
- Reset (trst=1 at a rising edge): state <= TEST_LOGIC_RESET and latched IR <= IDCODE. tdo_pad_o, tdo_padoe_o and the IR/IDCODE/bypass shift registers all clear to 0.
- Reset outcome: all state strobes and select outputs are 0. trst overrides tms. Reset mid-shift discards partial shift data with no update.
- FSM: standard 16 states with IEEE transitions on tms at each rising tck.
- Five consecutive tms=1 from any state reaches TEST_LOGIC_RESET. Entering TEST_LOGIC_RESET forces latched IR <= IDCODE.
- State strobes are a Moore decode of the state register.
- CAPTURE_IR: IR shift register <= 4'b0101.
- SHIFT_IR: IR shift register shifts right; tdi enters the MSB.
- IR update: on the edge where state == UPDATE_IR, latched IR <= IR shift register. Selects change the cycle after that edge.
- Instruction codes: EXTEST 4'b0000, SAMPLE_PRELOAD 4'b0001, IDCODE 4'b0010, DEBUG 4'b1000, MBIST 4'b1001, BYPASS 4'b1111.
- Any other code behaves as BYPASS, with all selects 0.
- IDCODE register: CAPTURE_DR loads IDCODE_VALUE when IR == IDCODE. SHIFT_DR shifts right with tdi into bit 31.
- Bypass register: CAPTURE_DR loads 0. SHIFT_DR loads tdi. Active when IR is BYPASS or unknown.
- TDO mux (serial-out bit at the current edge, before the shift):
  - SHIFT_IR: IR shift register bit 0.
  - SHIFT_DR with IDCODE: IDCODE register bit 0.
  - SHIFT_DR with BYPASS or unknown: bypass bit.
  - SHIFT_DR with EXTEST or SAMPLE_PRELOAD: bs_chain_tdi_i.
  - SHIFT_DR with MBIST: mbist_tdi_i.
  - SHIFT_DR with DEBUG: debug_tdi_i.
- TDO output timing: at each rising edge, tdo_pad_o <= mux and tdo_padoe_o <= (state is SHIFT_IR or SHIFT_DR). Bits therefore appear one tck after being shifted.
- Outside shift states: tdo_padoe_o = 0 and tdo_pad_o holds its last value.
- External chains own their capture/update; this block only provides strobes and selects.

Decomposition:
- Package jtag_pkg: tap_state_e enum (16 states), IR_WIDTH, instruction code localparams, default IDCODE.
- Sub-module jtag_tap_fsm: state register plus next-state logic and strobe decode. The top level holds IR, DR and the TDO mux.

Test Plan:
- trst=1 for 1 tck → all outputs 0, state TEST_LOGIC_RESET, IR == IDCODE, all selects 0.
- From reset, tms 0,1,0,0, then 32 cycles with tms=0 and the final shift cycle at tms=1 → tdo_pad_o yields 0x149511C3 LSB first, lagged 1 tck; tdo_padoe_o=1 over the same window; shift_dr_o=1 only in SHIFT_DR.
- Shift IR 4'b1111 (tdi 1,1,1,1) → tdo_pad_o 1,0,1,0. Then SHIFT_DR with tdi 1,0,1,1 → tdo_pad_o 0,1,0,1; all selects 0.
- Load EXTEST 4'b0000 → extest_select_o=1 the cycle after UPDATE_IR. In SHIFT_DR, tdo_pad_o follows bs_chain_tdi_i with 1 tck lag and tdo_o == tdi.
- Load MBIST, then DEBUG → mbist_select_o, then debug_select_o, are one-hot. tdo_pad_o tracks mbist_tdi_i, then debug_tdi_i.
- Load 4'b0111 → behaves as BYPASS with 1-bit delay. tms=1 for 5 tck mid-SHIFT_DR → TEST_LOGIC_RESET, IR == IDCODE. trst mid-SHIFT_IR → IR unchanged from IDCODE.
